pc_adder: RTL and testbench
===========================

PC_ADDER -- requirements
Module: pc_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the PC width in bits.
REQ-002 The block SHALL have parameter STEP, default 4, giving the increment added to the PC.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 old  input  WIDTH  current PC value.
REQ-006 en  input  1  register-update enable.
REQ-007 newv  output  WIDTH  combinational next PC (old + STEP).
REQ-008 newv_q  output  WIDTH  registered copy of newv.
REQ-009 valid_q  output  1  newv_q holds a value captured since reset.
REQ-010 wrap  output  1  combinational carry-out of old + STEP.
REQ-011 wrap_q  output  1  registered copy of wrap.
REQ-012 misalign  output  1  combinational flag: old not a multiple of STEP; present only with PC_ADDER_ALIGN_CHECK_EN.

Function
REQ-013 newv SHALL equal (old + STEP) modulo 2^WIDTH, purely combinational, zero-cycle latency, independent of clk, rst and en.
REQ-014 wrap SHALL be 1 exactly when old + STEP >= 2^WIDTH; in that case newv SHALL hold the truncated low WIDTH bits.
REQ-015 On a rising clk edge with rst=0 and en=1, newv_q SHALL load newv, wrap_q SHALL load wrap, and valid_q SHALL become 1.
REQ-016 On a rising clk edge with rst=0 and en=0, newv_q, wrap_q and valid_q SHALL hold their values.
REQ-017 The registered outputs SHALL have one-cycle latency: they reflect the old sampled at the preceding enabled edge.
REQ-018 old with X/Z bits SHALL NOT be captured when en=0.
REQ-019 STEP SHALL be a power of two, 1 <= STEP < 2^WIDTH; other values SHALL be rejected at elaboration with a fatal error.

Reset
REQ-020 When rst=1 at a rising clk edge, newv_q SHALL become 0, wrap_q SHALL become 0 and valid_q SHALL become 0, regardless of en.
REQ-021 rst SHALL take priority over en on the same edge.
REQ-022 rst SHALL NOT affect the combinational outputs newv, wrap or misalign.
REQ-023 Reset asserted mid-operation SHALL discard the captured value, with no residual state after the reset edge.

Configuration
REQ-024 Macro PC_ADDER_ALIGN_CHECK_EN defined: the misalign port SHALL exist and be 1 when old[log2(STEP)-1:0] != 0, combinational; with STEP=1 it SHALL be constant 0.
REQ-025 Macro PC_ADDER_ALIGN_CHECK_EN undefined: the misalign port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-026 old=4 -> newv=8, wrap=0; with en=1, after the next edge newv_q=8 and valid_q=1.
REQ-027 old=5 -> newv=9, wrap=0; with the macro defined misalign=1, and with old=8 misalign=0.
REQ-028 old=0xFFFFFFFC -> newv=0x00000000, wrap=1; after an enabled edge wrap_q=1.
REQ-029 newv_q=8, then en=0 and old=100 for 3 edges -> newv_q stays 8 while newv=104.
REQ-030 rst=1 and en=1 on the same edge with old=4 -> newv_q=0, valid_q=0, wrap_q=0, while newv=8 continuously.
REQ-031 Elaboration with STEP=3 -> fatal error.

Source files
------------

// File: rtl/pc_adder_if.sv
// PC adder bus: current PC and update enable in; next PC, carry and their
// registered copies out. The optional misalign flag exists only when
// PC_ADDER_ALIGN_CHECK_EN is defined.
interface pc_adder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] old;
  logic             en;
  logic [WIDTH-1:0] newv;
  logic [WIDTH-1:0] newv_q;
  logic             valid_q;
  logic             wrap;
  logic             wrap_q;
`ifdef PC_ADDER_ALIGN_CHECK_EN
  logic             misalign;

  modport master (
    output old, en,
    input  newv, newv_q, valid_q, wrap, wrap_q, misalign
  );

  modport slave (
    input  old, en,
    output newv, newv_q, valid_q, wrap, wrap_q, misalign
  );
`else
  modport master (
    output old, en,
    input  newv, newv_q, valid_q, wrap, wrap_q
  );

  modport slave (
    input  old, en,
    output newv, newv_q, valid_q, wrap, wrap_q
  );
`endif
endinterface

// File: rtl/pc_adder.sv
// PC incrementer: newv = old + STEP (mod 2^WIDTH) with carry-out in wrap,
// plus an enable-gated registered copy (newv_q, wrap_q, valid_q).
// Optional feature macro: PC_ADDER_ALIGN_CHECK_EN adds a combinational
// misalign flag (old not a multiple of STEP).
// Reset is synchronous and active-high; it clears only the registered side.
module pc_adder #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  pc_adder_if.slave   bus
);

  // STEP must be a power of two in [1, 2^WIDTH); anything else is a build error.
  if ((STEP < 1) || ((STEP & (STEP - 1)) != 0) ||
      ((WIDTH < 62) && (longint'(STEP) >= (longint'(1) << WIDTH)))) begin : g_bad_step
    $fatal(1, "pc_adder: STEP=%0d must be a power of two with 1 <= STEP < 2^WIDTH", STEP);
  end

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

  // One extra bit on the sum captures the carry-out.
  logic [WIDTH:0] sum;

  assign sum      = {1'b0, bus.old} + STEP_EXT;
  assign bus.newv = sum[WIDTH-1:0];
  assign bus.wrap = sum[WIDTH];

`ifdef PC_ADDER_ALIGN_CHECK_EN
  // Alignment means the low log2(STEP) bits are zero; STEP=1 is always aligned.
  if (STEP == 1) begin : g_align_trivial
    assign bus.misalign = 1'b0;
  end else begin : g_align_check
    localparam int ALIGN_BITS = $clog2(STEP);
    assign bus.misalign = |bus.old[ALIGN_BITS-1:0];
  end
`endif

  logic [WIDTH-1:0] newv_r;
  logic             wrap_r;
  logic             valid_r;

  // Capture next PC and carry on enabled edges; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      newv_r  <= '0;
      wrap_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (bus.en) begin
      newv_r  <= sum[WIDTH-1:0];
      wrap_r  <= sum[WIDTH];
      valid_r <= 1'b1;
    end
  end

  assign bus.newv_q  = newv_r;
  assign bus.wrap_q  = wrap_r;
  assign bus.valid_q = valid_r;

endmodule

// File: tb/tb_pc_adder.sv
// Self-checking bench for pc_adder (WIDTH=32, STEP=4): directed vector table,
// an X-on-old hold sequence, then random stimulus against a reference model.
module tb_pc_adder;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;

  logic clk;
  logic rst;

  pc_adder_if #(.WIDTH(WIDTH)) bus ();

  pc_adder #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference registered state, updated from the behavioural rules.
  logic [31:0] m_q;
  logic        m_v;
  logic        m_w;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] old;
    logic [31:0] exp_newv;
    logic        exp_wrap;
    logic [31:0] exp_q;
    logic        exp_v;
    logic        exp_wq;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_newv(input logic [31:0] o);
    longint s;
    s = longint'(o) + longint'(STEP);
    return 32'(s % (longint'(1) << 32));
  endfunction

  function automatic logic ref_wrap(input logic [31:0] o);
    longint s;
    s = longint'(o) + longint'(STEP);
    return (s >= (longint'(1) << 32));
  endfunction

  // Drive one cycle: check combinational outputs before the edge, update the
  // model with the edge rules, check the registered outputs after the edge.
  task automatic apply(input logic r, input logic e, input logic [31:0] o, input bit comb_chk);
    rst     = r;
    bus.en  = e;
    bus.old = o;
    #1;
    if (comb_chk) begin
      chk("newv", bus.newv, ref_newv(o));
      chk("wrap", 32'(bus.wrap), 32'(ref_wrap(o)));
`ifdef PC_ADDER_ALIGN_CHECK_EN
      chk("misalign", 32'(bus.misalign), 32'((o % STEP) != 0));
`endif
    end
    @(posedge clk);
    if (r) begin
      m_q = 32'd0; m_v = 1'b0; m_w = 1'b0;
    end else if (e) begin
      m_q = ref_newv(o); m_v = 1'b1; m_w = ref_wrap(o);
    end
    #1;
    chk("newv_q", bus.newv_q, m_q);
    chk("valid_q", 32'(bus.valid_q), 32'(m_v));
    chk("wrap_q", 32'(bus.wrap_q), 32'(m_w));
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.old = 32'd0;
    m_q = 32'd0; m_v = 1'b0; m_w = 1'b0;

    //            rst   en    old            newv           wrap  newv_q         valid wrap_q
    vecs[0]  = '{1'b1, 1'b1, 32'd4,         32'd8,         1'b0, 32'd0,         1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'd4,         32'd8,         1'b0, 32'd8,         1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'd100,       32'd104,       1'b0, 32'd8,         1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'd100,       32'd104,       1'b0, 32'd8,         1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'd100,       32'd104,       1'b0, 32'd8,         1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'd5,         32'd9,         1'b0, 32'd9,         1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 32'hFFFFFFFC,  32'h00000000,  1'b1, 32'h00000000,  1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 32'd8,         32'd12,        1'b0, 32'h00000000,  1'b1, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 32'hFFFFFFFF,  32'h00000003,  1'b1, 32'h00000003,  1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'd0,         32'd4,         1'b0, 32'd0,         1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'd10,        32'd14,        1'b0, 32'd0,         1'b0, 1'b0};

    // Initial reset, then the reset state itself.
    @(posedge clk); @(posedge clk); #1;
    chk("reset newv_q", bus.newv_q, 32'd0);
    chk("reset valid_q", 32'(bus.valid_q), 32'd0);
    chk("reset wrap_q", 32'(bus.wrap_q), 32'd0);

    // Directed table.
    for (int i = 0; i < 11; i++) begin
      rst     = vecs[i].rst;
      bus.en  = vecs[i].en;
      bus.old = vecs[i].old;
      #1;
      chk($sformatf("tbl%0d newv", i), bus.newv, vecs[i].exp_newv);
      chk($sformatf("tbl%0d wrap", i), 32'(bus.wrap), 32'(vecs[i].exp_wrap));
`ifdef PC_ADDER_ALIGN_CHECK_EN
      chk($sformatf("tbl%0d misalign", i), 32'(bus.misalign), 32'(vecs[i].old[1:0] != 2'b00));
`endif
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d newv after edge", i), bus.newv, vecs[i].exp_newv);
      chk($sformatf("tbl%0d newv_q", i), bus.newv_q, vecs[i].exp_q);
      chk($sformatf("tbl%0d valid_q", i), 32'(bus.valid_q), 32'(vecs[i].exp_v));
      chk($sformatf("tbl%0d wrap_q", i), 32'(bus.wrap_q), 32'(vecs[i].exp_wq));
    end
    m_q = 32'd0; m_v = 1'b0; m_w = 1'b0;

    // Hold sequence: capture a value, then drive X on old with en low.
    apply(1'b0, 1'b1, 32'h00001230, 1'b1);
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b0, 32'bx, 1'b0);
    end
    chk("x hold newv_q", bus.newv_q, 32'h00001234);

    // Mid-operation reset leaves nothing behind.
    apply(1'b1, 1'b1, 32'h00000040, 1'b1);
    apply(1'b0, 1'b0, 32'h00000080, 1'b1);

    // Random stimulus against the model, biased toward the wrap boundary.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] o;
      logic        r;
      logic        e;
      case ($urandom_range(0, 3))
        0:       o = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
        1:       o = 32'($urandom_range(0, 64));
        default: o = $urandom;
      endcase
      r = ($urandom_range(0, 19) == 0);
      e = $urandom_range(0, 1) == 1;
      apply(r, e, o, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
